// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Bundles every signal between branch_ctrl and its neighbours:
//   - decode request handshake (req_*) carrying funct3, operands, PC, imm and
//     the fetch prediction
//   - shared comparator drive (cmp_func/op_a/op_b) and its result (cmp_res)
//   - fetch redirect handshake (redir_valid/redir_pc/redir_ack) and flush
//   - resolution pulse (resolved_valid/resolved_taken)
//   - statistics counters (branch_cnt/mispred_cnt) and their clear (clr_cnt)
// Modports:
//   slave  - the branch_ctrl block itself
//   master - the surrounding pipeline (decode, comparator, fetch)
// -----------------------------------------------------------------------------
interface branch_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_func;
  logic [XLEN-1:0]  req_op_a;
  logic [XLEN-1:0]  req_op_b;
  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  req_imm;
  logic             req_pred_taken;

  logic [2:0]       cmp_func;
  logic [XLEN-1:0]  cmp_op_a;
  logic [XLEN-1:0]  cmp_op_b;
  logic             cmp_res;

  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic             redir_ack;
  logic             flush;

  logic             resolved_valid;
  logic             resolved_taken;

  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             clr_cnt;

  modport slave (
    input  req_valid, req_func, req_op_a, req_op_b, req_pc, req_imm,
           req_pred_taken, cmp_res, redir_ack, clr_cnt,
    output req_ready, cmp_func, cmp_op_a, cmp_op_b, redir_valid, redir_pc,
           flush, resolved_valid, resolved_taken, branch_cnt, mispred_cnt
  );

  modport master (
    output req_valid, req_func, req_op_a, req_op_b, req_pc, req_imm,
           req_pred_taken, cmp_res, redir_ack, clr_cnt,
    input  req_ready, cmp_func, cmp_op_a, cmp_op_b, redir_valid, redir_pc,
           flush, resolved_valid, resolved_taken, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Execute-stage branch resolution sequencer. Accepts one branch from decode,
// drives the shared comparator from latched operands, computes the target,
// checks the fetch prediction and, on a mispredict, raises flush and holds a
// redirect until fetch acknowledges it. Keeps saturating statistics counters.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - branch_ctrl_if.slave (request, comparator, redirect, counters)
// -----------------------------------------------------------------------------
module branch_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

  state_t           r_state;
  state_t           w_state_next;

  logic [2:0]       r_func;
  logic [XLEN-1:0]  r_op_a;
  logic [XLEN-1:0]  r_op_b;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic             r_pred;

  logic             r_redir_valid;
  logic [XLEN-1:0]  r_redir_pc;

  // index 0: resolved branches, index 1: mispredicted branches
  logic [CNT_W-1:0] r_cnt [2];
  logic             w_cnt_inc [2];

  logic             w_req_ready;
  logic             w_accept;
  logic             w_resolve;
  logic             w_taken;
  logic             w_mispred;
  logic             w_redir_done;
  logic [XLEN-1:0]  w_target;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and per-state strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_accept     = 1'b0;
    w_resolve    = 1'b0;
    w_taken      = 1'b0;
    w_mispred    = 1'b0;
    w_redir_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        // cmp_res is combinational from the latched cmp_* drive, so the
        // outcome is available in this single resolve cycle.
        w_resolve    = 1'b1;
        w_taken      = bus.cmp_res;
        w_mispred    = (bus.cmp_res != r_pred);
        w_state_next = w_mispred ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: begin
        // an ack is only meaningful while a redirect is actually offered
        if (r_redir_valid && bus.redir_ack) begin
          w_redir_done = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // target wraps modulo 2^XLEN through the natural adder width
  assign w_target = bus.cmp_res ? (r_pc + r_imm) : (r_pc + PC_STEP);

  // ---------------------------------------------------------------------------
  // Request latch and redirect register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func        <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_pc          <= '0;
      r_imm         <= '0;
      r_pred        <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      if (w_accept) begin
        r_func <= bus.req_func;
        r_op_a <= bus.req_op_a;
        r_op_b <= bus.req_op_b;
        r_pc   <= bus.req_pc;
        r_imm  <= bus.req_imm;
        r_pred <= bus.req_pred_taken;
      end
      if (w_resolve && w_mispred) begin
        r_redir_valid <= 1'b1;
        r_redir_pc    <= w_target;
      end else if (w_redir_done) begin
        r_redir_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics counters; clear wins over a same-cycle increment
  // ---------------------------------------------------------------------------
  assign w_cnt_inc[0] = w_resolve;
  assign w_cnt_inc[1] = w_resolve && w_mispred;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[gi] <= '0;
        end else if (bus.clr_cnt) begin
          r_cnt[gi] <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt[gi] != CNT_MAX)) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready      = w_req_ready;
  assign bus.cmp_func       = r_func;
  assign bus.cmp_op_a       = r_op_a;
  assign bus.cmp_op_b       = r_op_b;
  assign bus.redir_valid    = r_redir_valid;
  assign bus.redir_pc       = r_redir_pc;
  assign bus.flush          = w_resolve && w_mispred;
  assign bus.resolved_valid = w_resolve;
  assign bus.resolved_taken = w_taken;
  assign bus.branch_cnt     = r_cnt[0];
  assign bus.mispred_cnt    = r_cnt[1];

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl. A cycle-scheduled reference model in the
// driver sets the expected value of every output for each cycle from the
// branch rules (outcome, target, latency, redirect hold, saturating counters);
// one compare process checks the DUT at every falling edge. Counters use a
// narrow width so saturation is reachable quickly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_ctrl;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bif ();

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // branch compare rule, used both as the environment's comparator and by the
  // model on the original request operands
  function automatic logic ref_cmp(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign bif.cmp_res = ref_cmp(bif.cmp_func, bif.cmp_op_a, bif.cmp_op_b);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // expected outputs for the current cycle
  logic             e_ready, e_rv, e_rt, e_flush, e_rdv;
  logic [XLEN-1:0]  e_rdpc, e_cmp_a, e_cmp_b;
  logic [2:0]       e_cmp_f;
  logic [CNT_W-1:0] m_b, m_m;
  bit               chk_en = 0;
  // events of the current cycle that change the counters at the next edge
  bit               cur_res, cur_mis, cur_clr;

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready",      64'(bif.req_ready),      64'(e_ready));
      check("resolved_valid", 64'(bif.resolved_valid), 64'(e_rv));
      check("resolved_taken", 64'(bif.resolved_taken), 64'(e_rt));
      check("flush",          64'(bif.flush),          64'(e_flush));
      check("redir_valid",    64'(bif.redir_valid),    64'(e_rdv));
      if (e_rdv) check("redir_pc", bif.redir_pc, e_rdpc);
      check("cmp_func",       64'(bif.cmp_func),       64'(e_cmp_f));
      check("cmp_op_a",       bif.cmp_op_a,            e_cmp_a);
      check("cmp_op_b",       bif.cmp_op_b,            e_cmp_b);
      check("branch_cnt",     64'(bif.branch_cnt),     64'(m_b));
      check("mispred_cnt",    64'(bif.mispred_cnt),    64'(m_m));
    end
  end

  // advance one cycle: apply counter effects of the cycle just ended, then
  // default expectations and inputs for an idle cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (!rst_n || cur_clr) begin
      m_b = '0;
      m_m = '0;
    end else if (cur_res) begin
      m_b = sat_inc(m_b);
      if (cur_mis) m_m = sat_inc(m_m);
    end
    cur_res = 0; cur_mis = 0; cur_clr = 0;
    e_ready = 1'b1; e_rv = 1'b0; e_rt = 1'b0; e_flush = 1'b0; e_rdv = 1'b0;
    bif.req_valid = 1'b0;
    bif.redir_ack = 1'b0;
    bif.clr_cnt   = 1'b0;
  endtask

  task automatic drive_req(input logic [2:0] f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] imm, input logic pred);
    bif.req_valid      = 1'b1;
    bif.req_func       = f;
    bif.req_op_a       = a;
    bif.req_op_b       = b;
    bif.req_pc         = pc;
    bif.req_imm        = imm;
    bif.req_pred_taken = pred;
  endtask

  // random request presented while the block is busy; it must be ignored
  task automatic junk();
    if ($urandom_range(1) == 1)
      drive_req(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endtask

  // One branch, starting in an idle cycle and returning in the next idle cycle.
  task automatic do_branch(input logic [2:0] f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] imm, input logic pred,
                           input int ack_dly, input bit clr_res, input bit rst_abort,
                           input bit lit_en, input logic lit_taken,
                           input logic [XLEN-1:0] lit_pc);
    logic tk, mis;
    logic [XLEN-1:0] tgt;
    tk  = ref_cmp(f, a, b);
    tgt = tk ? pc + imm : pc + 64'd4;
    mis = (tk != pred);
    drive_req(f, a, b, pc, imm, pred);
    next_cycle();
    // resolve cycle
    e_cmp_f = f; e_cmp_a = a; e_cmp_b = b;
    e_ready = 1'b0; e_rv = 1'b1; e_rt = tk; e_flush = mis;
    cur_res = 1; cur_mis = mis;
    if (clr_res) begin
      bif.clr_cnt = 1'b1;
      cur_clr = 1;
    end
    junk();
    if (lit_en) begin
      #2;
      check("lit_resolved_taken", 64'(bif.resolved_taken), 64'(lit_taken));
    end
    if (mis) begin
      for (int k = 0; k <= ack_dly; k++) begin
        next_cycle();
        if (rst_abort) begin
          check("pre_rst_redir_valid", 64'(bif.redir_valid), 64'd1);
          rst_n = 1'b0;
          #1;
          check("rst_redir_valid", 64'(bif.redir_valid), 64'd0);
          check("rst_req_ready",   64'(bif.req_ready),   64'd1);
          check("rst_branch_cnt",  64'(bif.branch_cnt),  64'd0);
          check("rst_cmp_op_a",    bif.cmp_op_a,         64'd0);
          m_b = '0; m_m = '0;
          e_cmp_f = '0; e_cmp_a = '0; e_cmp_b = '0;
          return;
        end
        e_ready = 1'b0; e_rdv = 1'b1; e_rdpc = tgt;
        junk();
        bif.redir_ack = (k == ack_dly);
        if (lit_en && k == 0) begin
          #2;
          check("lit_redir_pc", bif.redir_pc, lit_pc);
        end
      end
    end
    next_cycle();
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    bif.req_valid = 1'b0; bif.req_func = '0; bif.req_op_a = '0; bif.req_op_b = '0;
    bif.req_pc = '0; bif.req_imm = '0; bif.req_pred_taken = 1'b0;
    bif.redir_ack = 1'b0; bif.clr_cnt = 1'b0;
    e_ready = 1'b1; e_rv = 1'b0; e_rt = 1'b0; e_flush = 1'b0; e_rdv = 1'b0;
    e_rdpc = '0; e_cmp_a = '0; e_cmp_b = '0; e_cmp_f = '0;
    m_b = '0; m_m = '0;
    cur_res = 0; cur_mis = 0; cur_clr = 0;

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("reset_req_ready",   64'(bif.req_ready),   64'd1);
    check("reset_redir_valid", 64'(bif.redir_valid), 64'd0);
    check("reset_redir_pc",    bif.redir_pc,         64'd0);
    check("reset_cmp_op_b",    bif.cmp_op_b,         64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();

    // BEQ equal, predicted taken: no mispredict
    do_branch(3'b000, 64'h5, 64'h5, 64'h1000, 64'h20, 1'b1, 0, 0, 0, 1, 1'b1, 64'h1020);
    check("t1_ready_n2",    64'(bif.req_ready),   64'd1);
    check("t1_branch_cnt",  64'(bif.branch_cnt),  64'd1);
    check("t1_mispred_cnt", 64'(bif.mispred_cnt), 64'd0);
    // BLT -1 < 1, predicted not taken, ack held off 3 cycles
    do_branch(3'b100, '1, 64'h1, 64'h2000, 64'h40, 1'b0, 3, 0, 0, 1, 1'b1, 64'h2040);
    check("t2_mispred_cnt", 64'(bif.mispred_cnt), 64'd1);
    // BLTU: 0xFF..F is not below 1
    do_branch(3'b110, '1, 64'h1, 64'h3000, 64'h40, 1'b1, 1, 0, 0, 1, 1'b0, 64'h3004);
    // BGEU on the same operands is taken
    do_branch(3'b111, '1, 64'h1, 64'h3000, 64'h40, 1'b0, 0, 0, 0, 1, 1'b1, 64'h3040);
    // target wraps past 2^64
    do_branch(3'b001, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 2, 0, 0, 1, 1'b1, 64'h10);
    // illegal funct3 compares false even on equal operands
    do_branch(3'b010, 64'h7, 64'h7, 64'h4000, 64'h8, 1'b1, 0, 0, 0, 1, 1'b0, 64'h4004);
    do_branch(3'b011, 64'h9, 64'h9, 64'h5000, 64'h8, 1'b1, 1, 0, 0, 1, 1'b0, 64'h5004);
    // back-to-back correctly predicted branches, two cycles apart
    do_branch(3'b101, 64'h3, 64'h3, 64'h6000, 64'h10, 1'b1, 0, 0, 0, 0, 1'b0, 64'h0);
    do_branch(3'b000, 64'h1, 64'h2, 64'h6004, 64'h10, 1'b0, 0, 0, 0, 0, 1'b0, 64'h0);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(3) == 0) ? ra : {$urandom, $urandom};
      do_branch(3'($urandom_range(7)), ra, rb, {$urandom, $urandom}, {$urandom, $urandom},
                1'($urandom_range(1)), int'($urandom_range(3)), ($urandom_range(9) == 0),
                0, 0, 1'b0, 64'h0);
      repeat ($urandom_range(2)) begin
        bif.redir_ack = 1'($urandom_range(1));
        if ($urandom_range(7) == 0) begin
          bif.clr_cnt = 1'b1;
          cur_clr = 1;
        end
        next_cycle();
      end
    end

    // saturation
    bif.clr_cnt = 1'b1;
    cur_clr = 1;
    next_cycle();
    for (int i = 0; i < 18; i++)
      do_branch(3'b000, 64'h1, 64'h1, 64'h100, 64'h8, 1'b1, 0, 0, 0, 0, 1'b0, 64'h0);
    check("sat_branch_cnt",  64'(bif.branch_cnt),  64'hF);
    check("sat_mispred_cnt", 64'(bif.mispred_cnt), 64'h0);
    for (int i = 0; i < 18; i++)
      do_branch(3'b000, 64'h1, 64'h1, 64'h100, 64'h8, 1'b0, 0, 0, 0, 0, 1'b0, 64'h0);
    check("sat_mispred_cnt2", 64'(bif.mispred_cnt), 64'hF);
    // clear wins over a same-cycle resolve
    do_branch(3'b000, 64'h1, 64'h1, 64'h100, 64'h8, 1'b0, 0, 1, 0, 0, 1'b0, 64'h0);
    check("clr_branch_cnt",  64'(bif.branch_cnt),  64'h0);
    check("clr_mispred_cnt", 64'(bif.mispred_cnt), 64'h0);

    // reset while a redirect is pending
    do_branch(3'b100, '1, 64'h1, 64'h7000, 64'h40, 1'b0, 2, 0, 1, 0, 1'b0, 64'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    do_branch(3'b000, 64'h2, 64'h2, 64'h8000, 64'h20, 1'b0, 0, 0, 0, 1, 1'b1, 64'h8020);
    check("post_rst_branch_cnt", 64'(bif.branch_cnt), 64'd1);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
